// File: rtl/seq_rotator.sv
// Serial 8-bit rotator: one bit per clock in SHIFT, optional bit-reverse on
// the way into the registered result y.
module seq_rotator (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [2:0] amt,
  input  logic       lr,
  input  logic       rev,
  output logic       ready,
  output logic       done,
  output logic [7:0] y,
  output logic [1:0] o_dbg_state
);

  // Handshake: an operation is accepted on any rising edge where start=1 and
  // ready=1; ready is high only in IDLE and done pulses for one cycle when y
  // holds the new result. start is ignored whenever ready=0.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_work;
  logic [2:0] r_cnt;
  logic       r_lr;
  logic       r_rev;
  logic [7:0] r_y;
  logic [7:0] w_rot;
  logic [7:0] w_final;
  logic [7:0] w_final_rev;
  logic       w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_rot = r_lr ? {r_work[6:0], r_work[7]} : {r_work[0], r_work[7:1]};
  end

  // Word that enters y: captured operand for amt=0, otherwise the last rotation.
  always_comb begin
    w_final = (r_state == S_IDLE) ? a : w_rot;
    for (int i = 0; i < 8; i++) begin
      w_final_rev[i] = w_final[7-i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (amt != 3'd0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_cnt == 3'd1) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work <= 8'h00;
      r_cnt  <= 3'd0;
      r_lr   <= 1'b0;
      r_rev  <= 1'b0;
      r_y    <= 8'h00;
    end else begin
      if (w_accept) begin
        r_work <= a;
        r_cnt  <= amt;
        r_lr   <= lr;
        r_rev  <= rev;
        if (amt == 3'd0) begin
          r_y <= rev ? w_final_rev : w_final;
        end
      end else if (r_state == S_SHIFT) begin
        r_work <= w_rot;
        r_cnt  <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_y <= r_rev ? w_final_rev : w_final;
        end
      end
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign done        = (r_state == S_DONE);
  assign y           = r_y;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_rotator.sv
// Bench for seq_rotator: directed and random operations checked against an
// arithmetic rotate/reverse model, plus busy, reset and back-to-back cases.
module tb_seq_rotator;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic       lr;
  logic       rev;
  logic       ready;
  logic       done;
  logic [7:0] y;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_y;

  seq_rotator dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .a           (a),
    .amt         (amt),
    .lr          (lr),
    .rev         (rev),
    .ready       (ready),
    .done        (done),
    .y           (y),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Reference model: rotate via a doubled word, reverse via bit index mirror.
  function automatic logic [7:0] model(input logic [7:0] ma, input int n,
                                       input logic mlr, input logic mrev);
    logic [15:0] d;
    logic [7:0]  r;
    logic [7:0]  o;
    d = {ma, ma};
    if (mlr) begin
      d = d << n;
      r = d[15:8];
    end else begin
      d = d >> n;
      r = d[7:0];
    end
    o = r;
    if (mrev) for (int i = 0; i < 8; i++) o[i] = r[7-i];
    return o;
  endfunction

  // Driver: one full operation, optionally poking start while busy.
  task automatic run_op(input logic [7:0] ta, input logic [2:0] tamt,
                        input logic tlr, input logic trev, input bit poke);
    logic [7:0] e;
    bit got;
    e = model(ta, int'(tamt), tlr, trev);
    exp_q.push_back(e);
    @(negedge clk);
    check("ready_before_start", ready, 1);
    a = ta; amt = tamt; lr = tlr; rev = trev; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); amt = 3'($urandom); lr = 1'($urandom); rev = 1'($urandom);
    got = 0;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        check("latency", n, int'(tamt));
        check("y_result", y, exp_q.pop_front());
        model_y = e;
        break;
      end
      check("busy_not_ready", ready, 0);
      check("y_hold_busy", y, model_y);
      if (poke && n == 0) begin
        start = 1'b1; a = ~ta; amt = 3'd1; lr = ~tlr;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", ready, 1);
    check("y_hold_after", y, model_y);
  endtask

  initial begin
    int last_done;
    int ndone;
    int nissued;
    reset_n = 1'b0; start = 1'b0; a = 8'h00; amt = 3'd0; lr = 1'b0; rev = 1'b0;
    model_y = 8'h00;
    #12;
    check("rst_y", y, 8'h00);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed operations
    run_op(8'b10010011, 3'd3, 1'b1, 1'b0, 0);
    check("dir_left3", y, 8'b10011100);
    run_op(8'b11100101, 3'd2, 1'b0, 1'b0, 0);
    check("dir_right2", y, 8'b01111001);
    run_op(8'b00111110, 3'd0, 1'b1, 1'b1, 0);
    check("dir_rev0", y, 8'b01111100);
    run_op(8'b10010011, 3'd1, 1'b1, 1'b1, 0);
    check("dir_rot_rev", y, 8'b11100100);
    run_op(8'hA5, 3'd5, 1'b0, 1'b0, 1);
    check("dir_busy_poke", y, 8'h2D);
    run_op(8'h81, 3'd7, 1'b1, 1'b0, 1);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      run_op(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             1'($urandom));
    end

    // Reset in the middle of a SHIFT run
    @(negedge clk);
    a = 8'hF0; amt = 3'd6; lr = 1'b1; rev = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_y", y, 8'h00);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    model_y = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst_no_done", done, 0);
      check("postrst_y", y, 8'h00);
    end

    // Back-to-back with start held, amt=7
    last_done = -1; ndone = 0; nissued = 0;
    for (int c = 0; c < 4 * 9 + 6; c++) begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() > 0) check("b2b_y", y, exp_q.pop_front());
        else check("b2b_extra_done", 1, 0);
        if (last_done >= 0) check("b2b_spacing", c - last_done, 9);
        last_done = c;
        ndone++;
      end
      if (ready) begin
        if (nissued < 4) begin
          a = 8'($urandom); amt = 3'd7; lr = 1'($urandom); rev = 1'($urandom);
          start = 1'b1;
          exp_q.push_back(model(a, 7, lr, rev));
          nissued++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_rotator.md
SEQ_ROTATOR -- requirements
Module: seq_rotator

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset; all other ports in REQ-002..REQ-010 are synchronous to clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only when ready=1.
REQ-005 a  input  8  operand word, captured on the accepting edge.
REQ-006 amt  input  3  rotate amount 0..7, captured on the accepting edge.
REQ-007 lr  input  1  direction, captured on the accepting edge: 1 = rotate left (toward MSB), 0 = rotate right.
REQ-008 rev  input  1  captured on the accepting edge: 1 = bit-reverse the rotated word before output (y[i] = r[7-i]).
REQ-009 ready  output  1  high only in IDLE.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 y  output  8  registered result; holds its value between done pulses.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the edge SHALL capture a into the work register, amt into the count register, and lr and rev into their registers.
REQ-014 On that edge, the FSM SHALL go to SHIFT if amt != 0, and to DONE if amt = 0.
REQ-015 Each SHIFT-state edge SHALL rotate the work register by one bit in the captured direction and decrement the count.
REQ-016 A SHIFT-state edge with count = 1 SHALL perform the last rotation and move the FSM to DONE.
REQ-017 Rotation SHALL be circular and lossless: rotating left moves bit 7 to bit 0; rotating right moves bit 0 to bit 7.
REQ-018 On the edge entering DONE, y SHALL load the final rotated word, bit-reversed if the captured rev = 1.
REQ-019 In the cases of REQ-018, y SHALL load the value the work register holds after that edge: after the last rotation when arriving from SHIFT, and the captured a when arriving from IDLE with amt = 0.
REQ-020 y SHALL change only on edges entering DONE and on reset.
REQ-021 done SHALL be a Moore output: high for exactly one cycle while in DONE.
REQ-022 The FSM SHALL always go from DONE to IDLE on the next edge.
REQ-023 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+amt, for every amt in 0..7.
REQ-024 ready SHALL return high after edge k+amt+1; the earliest next accepting edge is k+amt+2.
REQ-025 start SHALL be ignored outside IDLE, and changes on a/amt/lr/rev after the accepting edge SHALL NOT affect the operation in progress.
REQ-026 A held start SHALL launch a new operation on each edge where the FSM is in IDLE, so operations run back-to-back without idle gaps beyond the IDLE cycle.

Reset
REQ-027 reset_n = 0 SHALL immediately force the FSM to IDLE, y = 8'h00, done = 0 and ready = 1, with work and count registers cleared, independent of clk.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation with no done pulse and no y update.
REQ-029 The first accepting edge after reset_n deasserts SHALL behave per REQ-013.

Verification
REQ-030 Left rotate: a=8'b10010011, amt=3, lr=1, rev=0 accepted at edge k -> done high in the cycle after edge k+3 and y=8'b10011100.
REQ-031 Right rotate: a=8'b11100101, amt=2, lr=0, rev=0 -> done after 2 shift edges and y=8'b01111001.
REQ-032 Reverse with no rotation: a=8'b00111110, amt=0, lr=1, rev=1 -> done in the cycle after the accepting edge and y=8'b01111100.
REQ-033 Rotate then reverse: a=8'b10010011, amt=1, lr=1, rev=1 -> y=8'b11100100 (rotated 00100111, then bit-reversed).
REQ-034 Busy and reset: start pulsed while in SHIFT with different a -> ignored and the result is unchanged; a separate run with reset_n pulsed low mid-SHIFT -> y=8'h00, no done pulse, ready=1 immediately.
REQ-035 Back-to-back: start held high with amt=7 -> done pulses every 9 cycles, each with the correct rotated y.
